audio_decimator: RTL

Front-end sample-rate reducer that sits directly upstream of the tuner correlator. It accepts high-resolution signed codec samples over a valid/ready stream, sums `decim_p` consecutive samples, and emits one averaged, width-reduced Q1.11 sample per group. The output stream drives the tuner's `audio_i`/`valid_i`/`ready_o` port. A single output register provides backpressure toward the codec side.

---
 rtl/audio_decimator_if.sv | 21 ++
 rtl/audio_decimator.sv | 95 +++++++++
 2 files changed

// File: rtl/audio_decimator_if.sv
// Valid/ready sample stream bundle for the audio decimator.
// Ports: data (W bits), valid, ready; master drives data/valid.
interface audio_decimator_if #(
    parameter int W = 24
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/audio_decimator.sv
// Sums decim_p signed samples and emits one averaged Q1.(width_out_p-1) sample.
// Ports: clk_i, reset_i (sync, active-high); in: data_i/valid_i/ready_o;
//        out: data_o/valid_o/ready_i. Optional macro: DECIM_ROUND_EN
//        (round half up with positive saturation; floor truncation otherwise).
module audio_decimator #(
    parameter int width_in_p  = 24,
    parameter int width_out_p = 12,
    parameter int decim_p     = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_in_p-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [width_out_p-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    localparam int L  = $clog2(decim_p);
    localparam int S  = L + width_in_p - width_out_p;
    localparam int AW = width_in_p + L;

    logic [L-1:0]             r_count;
    logic signed [AW-1:0]     r_acc;
    logic [width_out_p-1:0]   r_data;
    logic                     r_valid;

    logic                     w_last;
    logic                     w_first;
    logic                     w_accept;
    logic signed [AW-1:0]     w_ext;
    logic signed [AW-1:0]     w_sum;
    logic [width_out_p-1:0]   w_res;

    assign w_last  = (r_count == L'(decim_p - 1));
    assign w_first = (r_count == '0);

    // Only the group's last sample needs the output register, so mid-group
    // samples are accepted even while the output is stalled.
    assign ready_o  = !(w_last && r_valid && !ready_i);
    assign w_accept = valid_i && ready_o;

    assign w_ext = {{L{data_i[width_in_p-1]}}, data_i};
    assign w_sum = r_acc + w_ext;

`ifdef DECIM_ROUND_EN
    // One extra bit so the half-LSB adder cannot overflow on a
    // full-scale positive group.
    localparam int SH = (S > 0) ? (S - 1) : 0;
    localparam logic signed [AW:0] RND =
        (S > 0) ? ((AW + 1)'(1) <<< SH) : '0;
    localparam logic signed [AW:0] MAXV =
        (AW + 1)'((1 << (width_out_p - 1)) - 1);

    logic signed [AW:0] w_rsum;
    logic signed [AW:0] w_rshr;

    assign w_rsum = {w_sum[AW-1], w_sum} + RND;
    assign w_rshr = w_rsum >>> S;

    // Rounding can only push past the top; the negative end is exact.
    always_comb begin
        w_res = width_out_p'(w_rshr);
        if (w_rshr > MAXV) begin
            w_res = {1'b0, {(width_out_p - 1){1'b1}}};
        end
    end
`else
    assign w_res = width_out_p'(w_sum >>> S);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= w_last ? '0 : r_count + 1'b1;
                r_acc   <= w_first ? w_ext : w_sum;
            end
            // Reload wins over consume: no bubble when both happen.
            if (w_accept && w_last) begin
                r_data  <= w_res;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
endmodule
